keypad_scanner: RTL and testbench

- Active driver for the 4x4 Pmod keypad on the JA header: strobes the column lines, samples the row lines, debounces, and emits one clean key event per physical press.
- Replaces passive decoding of the JA lines. Feeds the player-B movement/bomb logic in the bomberman top level with key code, held level, and one-cycle press/release pulses.

---
 rtl/keypad_scanner.sv | 172 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 keypad driver: strobes columns, samples synchronized rows, debounces full
// scans and reports one clean press/release event per stable key change.
module keypad_scanner #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_press,
  output logic       key_release
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_SCANS);
  // Nibble (4*col + row) holds the key code at that position.
  localparam logic [63:0] KEY_MAP = 64'hDCBA_E963_F852_0741;

  typedef enum logic [1:0] {COL0, COL1, COL2, COL3} scanState_t;
  typedef enum logic {RELEASED, PRESSED} keyState_t;

  scanState_t scanState, scanNext;
  keyState_t  keyState, keyNext;

  logic [DIV_W-1:0] divCnt;
  logic [3:0]       rowSync1, rowSync2;
  logic [3:0]       sample0, sample1, sample2;
  logic             colEnd, scanDone;
  logic             resValid;
  logic [3:0]       resCode;
  logic             candValid;
  logic [3:0]       candCode;
  logic [CNT_W-1:0] debCnt, cntNext;
  logic             resMatch, resDiffers;
  logic [3:0]       codeNext;
  logic             validNext, pressNext, releaseNext;

  assign colEnd   = (divCnt == DIV_W'(SCAN_DIV - 1));
  assign scanDone = colEnd && (scanState == COL3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rowSync1 <= '1;
      rowSync2 <= '1;
    end else begin
      rowSync1 <= row;
      rowSync2 <= rowSync1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      divCnt    <= '0;
      scanState <= COL0;
    end else begin
      divCnt    <= colEnd ? '0 : divCnt + 1'b1;
      scanState <= scanNext;
    end
  end

  always_comb begin
    scanNext = scanState;
    col      = 4'b1110;
    case (scanState)
      COL0: begin col = 4'b1110; if (colEnd) scanNext = COL1; end
      COL1: begin col = 4'b1101; if (colEnd) scanNext = COL2; end
      COL2: begin col = 4'b1011; if (colEnd) scanNext = COL3; end
      COL3: begin col = 4'b0111; if (colEnd) scanNext = COL0; end
      default: scanNext = COL0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample0 <= '1;
      sample1 <= '1;
      sample2 <= '1;
    end else if (colEnd) begin
      case (scanState)
        COL0:    sample0 <= rowSync2;
        COL1:    sample1 <= rowSync2;
        COL2:    sample2 <= rowSync2;
        default: ;
      endcase
    end
  end

  // Column 3 is taken straight from the synchronizer on the scan's final cycle.
  always_comb begin
    logic [15:0] scanRows;
    scanRows = {rowSync2, sample2, sample1, sample0};
    resValid = 1'b0;
    resCode  = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        if (!resValid && !scanRows[c*4 + r]) begin
          resValid = 1'b1;
          resCode  = KEY_MAP[(c*4 + r)*4 +: 4];
        end
      end
    end
  end

  assign resMatch = (resValid == candValid) && (!resValid || (resCode == candCode));
  assign cntNext  = !resMatch ? CNT_W'(1) :
                    (debCnt == DEB_MAX) ? DEB_MAX : debCnt + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      candValid <= 1'b0;
      candCode  <= '0;
      debCnt    <= '0;
    end else if (scanDone) begin
      candValid <= resValid;
      candCode  <= resCode;
      debCnt    <= cntNext;
    end
  end

  assign resDiffers = (keyState == RELEASED) ? resValid
                                             : (!resValid || (resCode != key_code));

  always_comb begin
    keyNext     = keyState;
    codeNext    = key_code;
    validNext   = key_valid;
    pressNext   = 1'b0;
    releaseNext = 1'b0;
    if (scanDone && (cntNext == DEB_MAX) && resDiffers) begin
      case (keyState)
        RELEASED: begin
          keyNext   = PRESSED;
          codeNext  = resCode;
          validNext = 1'b1;
          pressNext = 1'b1;
        end
        PRESSED: begin
          releaseNext = 1'b1;
          if (resValid) begin
            codeNext  = resCode;
            pressNext = 1'b1;
          end else begin
            keyNext   = RELEASED;
            validNext = 1'b0;
          end
        end
        default: keyNext = RELEASED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      keyState    <= RELEASED;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      keyState    <= keyNext;
      key_code    <= codeNext;
      key_valid   <= validNext;
      key_press   <= pressNext;
      key_release <= releaseNext;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model drives rows from held keys; a
// scan-level reference model predicts outputs, checked every cycle.
module tb_keypad_scanner;

  localparam int D   = 4;
  localparam int DEB = 3;
  localparam int SCAN = 4 * D;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid, key_press, key_release;

  logic [15:0] held = '0;
  int keyAt[4][4] = '{'{1, 4, 7, 0}, '{2, 5, 8, 15}, '{3, 6, 9, 14}, '{10, 11, 12, 13}};

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int candKey, candCnt, stableKey;
  logic [3:0] expCode;
  logic       expValid, expPress, expRelease;

  keypad_scanner #(.SCAN_DIV(D), .DEBOUNCE_SCANS(DEB)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col), .key_code(key_code),
    .key_valid(key_valid), .key_press(key_press), .key_release(key_release)
  );

  always #5 clk = ~clk;

  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!col[c] && held[keyAt[c][r]]) row[r] = 1'b0;
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int priorityKey();
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (held[keyAt[c][r]]) return keyAt[c][r];
    return -1;
  endfunction

  task automatic modelReset();
    candKey = -1; candCnt = 0; stableKey = -1;
    expCode = '0; expValid = 1'b0; expPress = 1'b0; expRelease = 1'b0;
  endtask

  task automatic modelScanEnd();
    int res;
    res = priorityKey();
    if (res == candKey) candCnt = (candCnt < DEB) ? candCnt + 1 : DEB;
    else begin candKey = res; candCnt = 1; end
    expPress = 1'b0; expRelease = 1'b0;
    if (candCnt == DEB && candKey != stableKey) begin
      if (stableKey != -1) expRelease = 1'b1;
      if (candKey != -1) begin
        expPress = 1'b1; expCode = 4'(candKey); expValid = 1'b1;
      end else expValid = 1'b0;
      stableKey = candKey;
    end
  endtask

  task automatic checkAll();
    logic [3:0] ec;
    ec = 4'b1111 ^ (4'b0001 << ((cyc / D) % 4));
    chk("col", col, ec);
    chk("key_code", key_code, expCode);
    chk("key_valid", {3'b0, key_valid}, {3'b0, expValid});
    chk("key_press", {3'b0, key_press}, {3'b0, expPress});
    chk("key_release", {3'b0, key_release}, {3'b0, expRelease});
  endtask

  task automatic tick();
    @(posedge clk);
    if (cyc % SCAN == SCAN - 1) modelScanEnd();
    else begin expPress = 1'b0; expRelease = 1'b0; end
    cyc++;
    #1;
    checkAll();
  endtask

  task automatic runScans(input int n);
    repeat (n * SCAN) tick();
  endtask

  task automatic releaseReset();
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    modelReset();
    #1;
    checkAll();
  endtask

  initial begin
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_col", col, 4'b1110);
    chk("reset_code", key_code, 4'h0);
    chk("reset_valid", {3'b0, key_valid}, 4'h0);
    chk("reset_pulses", {2'b0, key_press, key_release}, 4'h0);

    releaseReset();
    runScans(3);

    // Key 5 held from a fresh reset release.
    rst = 1'b0;
    held = 16'h0020;
    @(posedge clk);
    releaseReset();
    runScans(3);
    chk("k5_press_at_48", {3'b0, key_press}, 4'h1);
    chk("k5_code", key_code, 4'h5);
    runScans(2);

    held = '0;
    runScans(3);
    chk("k5_release", {3'b0, key_release}, 4'h1);
    chk("k5_code_hold", key_code, 4'h5);
    chk("k5_valid_low", {3'b0, key_valid}, 4'h0);
    runScans(1);

    for (int i = 0; i < 20; i++) begin
      held = (i % 2 == 0) ? 16'h0200 : 16'h0000;
      runScans(1);
    end
    chk("bounce_valid", {3'b0, key_valid}, 4'h0);
    held = '0;
    runScans(3);

    held = 16'h0042;
    runScans(3);
    chk("multi_code", key_code, 4'h1);
    chk("multi_press", {3'b0, key_press}, 4'h1);
    runScans(2);

    held = 16'h0040;
    runScans(3);
    chk("swap_pulses", {2'b0, key_press, key_release}, 4'h3);
    chk("swap_code", key_code, 4'h6);
    chk("swap_valid", {3'b0, key_valid}, 4'h1);
    runScans(1);

    // Randomized held-key segments aligned to scan boundaries.
    for (int seg = 0; seg < 14; seg++) begin
      int mode;
      mode = $urandom_range(0, 3);
      held = '0;
      if (mode != 0) held[$urandom_range(0, 15)] = 1'b1;
      if (mode == 3) held[$urandom_range(0, 15)] = 1'b1;
      runScans($urandom_range(1, 5));
    end

    held = 16'h2000;
    runScans(4);
    chk("kD_valid", {3'b0, key_valid}, 4'h1);
    repeat (9) tick();
    rst = 1'b0;
    #1;
    chk("async_rst_col", col, 4'b1110);
    chk("async_rst_code", key_code, 4'h0);
    chk("async_rst_outs", {1'b0, key_valid, key_press, key_release}, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_no_release", {3'b0, key_release}, 4'h0);
    releaseReset();
    runScans(3);
    chk("kD_press_at_48", {3'b0, key_press}, 4'h1);
    chk("kD_code", key_code, 4'hD);
    runScans(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
